// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
// Bit-serial adder: one full adder (two half adders + OR) reused over WIDTH cycles, LSB first.
// Latency: done pulses WIDTH+1 edges after start is accepted; one addition per WIDTH+2 cycles.
// No backpressure: start is sampled only in IDLE and is never queued. Optional ovf port: SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Single full adder built from two half-adder stages.
  logic             p;
  logic             g1;
  logic             s;
  logic             g2;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign p          = sh_a[0] ^ sh_b[0];
  assign g1         = sh_a[0] & sh_b[0];
  assign s          = p ^ carry;
  assign g2         = p & carry;
  assign carry_next = g1 | g2;
  assign res_next   = {s, sh_r[WIDTH-1:1]};
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        state_next = start ? RUN : IDLE;
      end
      RUN: begin
        busy       = 1'b1;
        state_next = last_bit ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_r  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          sh_r  <= res_next;
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= res_next;
            cout <= carry_next;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on the final bit.
            ovf  <= carry ^ carry_next;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_w;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf_w)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one addition; operands are scrambled after acceptance. Returns the
  // edge count from the accepting edge (inclusive) to the done cycle and the
  // number of busy cycles. edges hits 50 if done never arrives.
  task automatic do_op(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                       output logic [WIDTH-1:0] r_sum, output logic r_cout,
                       output logic r_ovf, output int edges, output int busy_cyc,
                       output int overlap);
    @(negedge clk);
    a = opa;
    b = opb;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    busy_cyc = 0;
    overlap = 0;
    @(negedge clk);
    start = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    while (!done && edges < 50) begin
      if (busy) busy_cyc++;
      if (busy && done) overlap++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (busy && done) overlap++;
    r_sum  = sum;
    r_cout = cout;
    r_ovf  = ovf_w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf_w} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf_w);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_zero_latency();
    logic [WIDTH-1:0] s;
    logic c, o;
    int e, bc, ov;
    do_op(8'h00, 8'h00, s, c, o, e, bc, ov);
    checks++;
    if (e !== 9) begin
      errors++;
      $display("FAIL latency: got %0d edges, want 9", e);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, want 8", bc);
    end
    checks++;
    if (s !== 8'h00 || c !== 1'b0 || ov !== 0) begin
      errors++;
      $display("FAIL add_00_00: got sum=%h cout=%b overlap=%0d, want 00 0 0", s, c, ov);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b, want 0", done);
    end
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va [3] = '{8'hFF, 8'hA5, 8'h3C};
    logic [WIDTH-1:0] vb [3] = '{8'h01, 8'h5A, 8'h0F};
    logic [WIDTH-1:0] es [3] = '{8'h00, 8'hFF, 8'h4B};
    logic             ec [3] = '{1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] s;
    logic c, o;
    int e, bc, ov;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], s, c, o, e, bc, ov);
      checks++;
      if (s !== es[i] || c !== ec[i] || e !== 9) begin
        errors++;
        $display("FAIL add_vec%0d: got sum=%h cout=%b edges=%0d, want %h %b 9",
                 i, s, c, e, es[i], ec[i]);
      end
    end
    // Result must be held through IDLE.
    repeat (4) @(negedge clk);
    checks++;
    if (sum !== 8'h4B || cout !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got sum=%h cout=%b, want 4b 0", sum, cout);
    end
  endtask

  task automatic test_start_held();
    int pulses = 0;
    int last_i = -1;
    int bad_gap = 0;
    int bad_sum = 0;
    int both = 0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        if (sum !== 8'h30 || cout !== 1'b0) bad_sum++;
        if (last_i >= 0 && (i - last_i) != 10) bad_gap++;
        last_i = i;
      end
      if (busy && done) both++;
      start = 1'b1;
      if (!busy && !done) begin
        a = 8'h10;
        b = 8'h20;
      end else begin
        a = 8'hFF;
        b = 8'hFF;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL held_pulses: got %0d, want 3", pulses);
    end
    checks++;
    if (bad_sum !== 0 || bad_gap !== 0 || both !== 0) begin
      errors++;
      $display("FAIL held_results: got bad_sum=%0d bad_gap=%0d busy_and_done=%0d, want 0 0 0",
               bad_sum, bad_gap, both);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] s;
    logic c, o;
    int e, bc, ov;
    int seen_done = 0;
    do_op(8'hFF, 8'h01, s, c, o, e, bc, ov);  // leaves sum=00 cout=1
    do_op(8'h3C, 8'h0F, s, c, o, e, bc, ov);  // leaves sum=4B
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf_w} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf_w);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", seen_done);
    end
    do_op(8'h01, 8'h02, s, c, o, e, bc, ov);
    checks++;
    if (s !== 8'h03 || c !== 1'b0 || e !== 9) begin
      errors++;
      $display("FAIL after_reset_op: got sum=%h cout=%b edges=%0d, want 03 0 9", s, c, e);
    end
  endtask

  task automatic test_ovf();
    logic [WIDTH-1:0] va [3] = '{8'h7F, 8'h80, 8'hFF};
    logic [WIDTH-1:0] vb [3] = '{8'h01, 8'h80, 8'h01};
    logic [WIDTH-1:0] es [3] = '{8'h80, 8'h00, 8'h00};
    logic             ec [3] = '{1'b0, 1'b1, 1'b1};
`ifdef SERIAL_ADD_OVF_EN
    logic             eo [3] = '{1'b1, 1'b1, 1'b0};
`else
    logic             eo [3] = '{1'b0, 1'b0, 1'b0};
`endif
    logic [WIDTH-1:0] s;
    logic c, o;
    int e, bc, ov;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], s, c, o, e, bc, ov);
      checks++;
      if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
        errors++;
        $display("FAIL ovf_vec%0d: got sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_vectors();
    test_start_held();
    test_reset_mid_run();
    test_ovf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
